// File: rtl/pipe_adder.sv
// pipe_adder: valid/ready adder split into STAGES carry-pipelined chunks of WIDTH/STAGES bits.
// Optional macro PIPE_ADDER_OVF_EN adds a registered two's-complement overflow output ovf.
module pipe_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipe_adder: WIDTH must be >= 2 and an exact multiple of STAGES");
  end

  logic                         advance;

  // Register index k holds what leaves stage k: valid, carry, operands, partial sum.
  logic [STAGES-1:0]            vld_q;
  logic [STAGES-1:0]            cry_q;
  logic [STAGES-1:0][WIDTH-1:0] a_q;
  logic [STAGES-1:0][WIDTH-1:0] b_q;
  logic [STAGES-1:0][WIDTH-1:0] sum_q;

  logic [STAGES-1:0]            vld_in;
  logic [STAGES-1:0]            cry_in;
  logic [STAGES-1:0][WIDTH-1:0] a_in;
  logic [STAGES-1:0][WIDTH-1:0] b_in;
  logic [STAGES-1:0][WIDTH-1:0] sum_in;

  logic [STAGES-1:0][CW:0]      chunk;
  logic [STAGES-1:0]            cry_nxt;
  logic [STAGES-1:0][WIDTH-1:0] sum_nxt;

  assign advance  = !vld_q[STAGES-1] || out_ready;
  assign in_ready = advance;

  always_comb begin
    vld_in    = '0;
    cry_in    = '0;
    a_in      = '0;
    b_in      = '0;
    sum_in    = '0;
    vld_in[0] = in_valid;
    cry_in[0] = cin;
    a_in[0]   = a;
    b_in[0]   = b;
    for (int k = 1; k < STAGES; k++) begin
      vld_in[k] = vld_q[k-1];
      cry_in[k] = cry_q[k-1];
      a_in[k]   = a_q[k-1];
      b_in[k]   = b_q[k-1];
      sum_in[k] = sum_q[k-1];
    end
  end

  // Stage k fills in chunk k of the running sum; lower chunks ride along unchanged.
  always_comb begin
    chunk   = '0;
    cry_nxt = '0;
    sum_nxt = '0;
    for (int k = 0; k < STAGES; k++) begin
      chunk[k]   = {1'b0, a_in[k][k*CW +: CW]} + {1'b0, b_in[k][k*CW +: CW]}
                 + {{CW{1'b0}}, cry_in[k]};
      cry_nxt[k] = chunk[k][CW];
      sum_nxt[k] = sum_in[k];
      sum_nxt[k][k*CW +: CW] = chunk[k][CW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      cry_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
    end else if (advance) begin
      vld_q <= vld_in;
      cry_q <= cry_nxt;
      a_q   <= a_in;
      b_q   <= b_in;
      sum_q <= sum_nxt;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = cry_q[STAGES-1];

`ifdef PIPE_ADDER_OVF_EN
  // The last stage sees the operand sign bits and produces the sum sign bit.
  logic ovf_nxt;

  assign ovf_nxt = (a_in[STAGES-1][WIDTH-1] == b_in[STAGES-1][WIDTH-1])
                && (chunk[STAGES-1][CW-1] != a_in[STAGES-1][WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (advance) begin
      ovf <= ovf_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed and randomized self-checking bench for pipe_adder (WIDTH=8, STAGES=2).
// Define PIPE_ADDER_OVF_EN to also connect and check the ovf output.
module tb_pipe_adder;
  localparam int WIDTH  = 8;
  localparam int STAGES = 2;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } beat_t;

  logic             clk       = 1'b0;
  logic             rst       = 1'b0;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] a         = '0;
  logic [WIDTH-1:0] b         = '0;
  logic             cin       = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef PIPE_ADDER_OVF_EN
  logic             ovf;
`endif

  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t exp_q[$];
  beat_t got_beat;
  logic  got;
  logic  last_acc;

  pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PIPE_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference: full-precision arithmetic, then split into sum/carry/overflow.
  function automatic beat_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic ci);
    logic [WIDTH:0] t;
    beat_t          r;
    t   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    r.s = t[WIDTH-1:0];
    r.c = t[WIDTH];
    r.o = 1'b0;
`ifdef PIPE_ADDER_OVF_EN
    r.o = (x[WIDTH-1] == y[WIDTH-1]) && (r.s[WIDTH-1] != x[WIDTH-1]);
`endif
    return r;
  endfunction

  // One clock: record handshakes seen before the edge, then step past it.
  task automatic tick();
    #1;
    last_acc   = in_valid && in_ready;
    got        = out_valid && out_ready;
    got_beat.s = sum;
    got_beat.c = cout;
`ifdef PIPE_ADDER_OVF_EN
    got_beat.o = ovf;
`else
    got_beat.o = 1'b0;
`endif
    if (last_acc) exp_q.push_back(model(a, b, cin));
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_operands();
    a   = WIDTH'($urandom);
    b   = WIDTH'($urandom);
    cin = 1'($urandom);
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    n_tests++;
    if ({sum, cout} !== {WIDTH+1{1'b0}}) begin
      n_fail++;
      $display("[TB] FAIL reset_sum_cout: got %h/%b expected 0/0", sum, cout);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL after_reset: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] va  [4] = '{8'h3C, 8'hFF, 8'h0F, 8'h7F};
    logic [WIDTH-1:0] vb  [4] = '{8'h0F, 8'h00, 8'h01, 8'h01};
    logic             vc  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [WIDTH-1:0] vs  [4] = '{8'h4C, 8'h00, 8'h10, 8'h80};
    logic             vco [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic             vo  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    string            nm  [4] = '{"single", "wrap", "carry_boundary", "signed_ovf"};
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a         = va[i];
      b         = vb[i];
      cin       = vc[i];
      tick();
      in_valid = 1'b0;
      for (int k = 1; k < STAGES; k++) begin
        n_tests++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL %s_early: got out_valid=%b expected 0", nm[i], out_valid);
        end
        tick();
      end
      n_tests++;
      if (out_valid !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL %s_latency: got out_valid=%b expected 1", nm[i], out_valid);
      end
      n_tests++;
      if ({sum, cout} !== {vs[i], vco[i]}) begin
        n_fail++;
        $display("[TB] FAIL %s_sum: got %h/%b expected %h/%b", nm[i], sum, cout, vs[i], vco[i]);
      end
`ifdef PIPE_ADDER_OVF_EN
      n_tests++;
      if (ovf !== vo[i]) begin
        n_fail++;
        $display("[TB] FAIL %s_ovf: got %b expected %b", nm[i], ovf, vo[i]);
      end
`else
      if (vo[i] === 1'bx) $display("[TB] note: undefined overflow table entry %0d", i);
`endif
      tick();
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    int    sent  = 0;
    int    recv  = 0;
    int    first = -1;
    int    last  = -1;
    beat_t exp;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 300 && recv < 256; cyc++) begin
      in_valid = (sent < 256);
      randomize_operands();
      tick();
      if (last_acc) sent++;
      if (got) begin
        recv++;
        if (first < 0) first = cyc;
        last = cyc;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL b2b_extra: got %h expected no beat", got_beat);
        end else begin
          exp = exp_q.pop_front();
          if (got_beat !== exp) begin
            n_fail++;
            $display("[TB] FAIL b2b_data: got %h expected %h (beat %0d)", got_beat, exp, recv);
          end
        end
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (recv !== 256) begin
      n_fail++;
      $display("[TB] FAIL b2b_count: got %0d beats expected 256", recv);
    end
    n_tests++;
    if (last - first + 1 !== 256) begin
      n_fail++;
      $display("[TB] FAIL b2b_throughput: got %0d cycles expected 256", last - first + 1);
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] held_s;
    logic             held_c;
    beat_t            exp;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      randomize_operands();
      tick();
    end
    held_s = sum;
    held_c = cout;
    n_tests++;
    if (out_valid !== 1'b1 || {held_s, held_c} !== {exp_q[0].s, exp_q[0].c}) begin
      n_fail++;
      $display("[TB] FAIL bp_head: got %b %h/%b expected 1 %h/%b",
               out_valid, held_s, held_c, exp_q[0].s, exp_q[0].c);
    end
    for (int i = 0; i < 5; i++) begin
      randomize_operands();
      tick();
      n_tests++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL bp_in_ready: got %b expected 0 (cycle %0d)", in_ready, i);
      end
      n_tests++;
      if ({sum, cout} !== {held_s, held_c}) begin
        n_fail++;
        $display("[TB] FAIL bp_frozen: got %h/%b expected %h/%b", sum, cout, held_s, held_c);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      tick();
      if (got) begin
        exp = exp_q.pop_front();
        n_tests++;
        if (got_beat !== exp) begin
          n_fail++;
          $display("[TB] FAIL bp_drain: got %h expected %h", got_beat, exp);
        end
      end
    end
    n_tests++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_lost: got %0d pending out_valid=%b expected 0/0", exp_q.size(), out_valid);
    end
    exp_q.delete();
  endtask

  task automatic test_random_flow();
    logic             stalled;
    logic [WIDTH-1:0] held_s;
    logic             held_c;
    beat_t            exp;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      randomize_operands();
      stalled = out_valid && !out_ready;
      held_s  = sum;
      held_c  = cout;
      tick();
      if (stalled) begin
        n_tests++;
        if (out_valid !== 1'b1 || {sum, cout} !== {held_s, held_c}) begin
          n_fail++;
          $display("[TB] FAIL rand_hold: got %b %h/%b expected 1 %h/%b", out_valid, sum, cout, held_s, held_c);
        end
      end
      if (got) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL rand_extra: got %h expected no beat", got_beat);
        end else begin
          exp = exp_q.pop_front();
          if (got_beat !== exp) begin
            n_fail++;
            $display("[TB] FAIL rand_data: got %h expected %h (cycle %0d)", got_beat, exp, cyc);
          end
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      tick();
      if (got) begin
        exp = exp_q.pop_front();
        n_tests++;
        if (got_beat !== exp) begin
          n_fail++;
          $display("[TB] FAIL rand_drain: got %h expected %h", got_beat, exp);
        end
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL rand_lost: got %0d beats pending expected 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midstream();
    int    stale = 0;
    beat_t exp;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      randomize_operands();
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midreset_flags: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    n_tests++;
    if ({sum, cout} !== {WIDTH+1{1'b0}}) begin
      n_fail++;
      $display("[TB] FAIL midreset_sum: got %h/%b expected 0/0", sum, cout);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (got || out_valid) stale++;
    end
    n_tests++;
    if (stale !== 0) begin
      n_fail++;
      $display("[TB] FAIL midreset_stale: got %0d stale beats expected 0", stale);
    end
    in_valid = 1'b1;
    randomize_operands();
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midreset_early: got out_valid=%b expected 0", out_valid);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || exp_q.size() != 1) begin
      n_fail++;
      $display("[TB] FAIL midreset_latency: got out_valid=%b queued=%0d expected 1/1", out_valid, exp_q.size());
    end else begin
      exp = exp_q.pop_front();
      n_tests++;
      if ({sum, cout} !== {exp.s, exp.c}) begin
        n_fail++;
        $display("[TB] FAIL midreset_first: got %h/%b expected %h/%b", sum, cout, exp.s, exp.c);
      end
    end
    tick();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random_flow();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
